muldiv_iter: RTL

Parametrised iterative multiply/divide unit for the EX stage. It computes HI/LO results for MULT/MULTU/DIV/DIVU.
- Replaces separate mul/div instances with one shared datapath.
- Uses a valid/ready handshake on both sides and a configurable radix.
- Supports annul for pipeline flush.
- EX stalls while in_valid && !out_valid for the instruction in flight.

---
 rtl/muldiv_iter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit for the EX stage.
// One shared shift/add (multiply) and restoring subtract/shift (divide)
// datapath retiring BITS_PER_CYCLE bits per cycle. Results are 2*WIDTH
// wide and returned as hi/lo.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   in_valid / in_ready request handshake (in_ready only in IDLE)
//   op                  op[1]=1 divide / 0 multiply, op[0]=1 signed
//   in_a, in_b          multiplicand/dividend, multiplier/divisor
//   annul               flush: abort the operation or drop a pending result
//   out_valid/out_ready result handshake
//   out_hi, out_lo      product high/low, or remainder/quotient
//   busy                unit is not idle
//   div_by_zero         divide with zero divisor, qualified by out_valid
module muldiv_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             annul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_accept;
  logic                 w_div0;
  logic [WIDTH:0]       w_a_ext;
  logic [WIDTH:0]       w_b_ext;
  logic [WIDTH:0]       w_a_mag;
  logic [WIDTH:0]       w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH:0]       w_sum;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_neg_acc;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  logic [1:0]           r_op;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_dbz;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;    // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH:0]       r_opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     r_out_hi;
  logic [WIDTH-1:0]     r_out_lo;
  logic                 r_out_dbz;

  // Operand decode: sign-extend to WIDTH+1 so |-2^(WIDTH-1)| is representable.
  assign w_div0    = op[1] && (in_b == {WIDTH{1'b0}});
  assign w_a_ext   = {op[0] & in_a[WIDTH-1], in_a};
  assign w_b_ext   = {op[0] & in_b[WIDTH-1], in_b};
  assign w_a_mag   = w_a_ext[WIDTH] ? -w_a_ext : w_a_ext;
  assign w_b_mag   = w_b_ext[WIDTH] ? -w_b_ext : w_b_ext;
  assign w_neg_acc = -r_acc;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !annul) begin
          w_accept    = 1'b1;
          // A zero divisor has a fixed answer, so skip the iterations.
          w_state_nxt = w_div0 ? S_FIX : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (annul) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FIX: begin
        if (annul) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (annul || out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One iteration: BITS_PER_CYCLE unrolled shift-add or restoring-divide steps.
  always_comb begin
    w_acc_step = r_acc;
    w_sum      = {(WIDTH+1){1'b0}};
    w_ge       = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_op[1]) begin
        // Partial remainder shifted left with the next dividend bit.
        w_sum = w_acc_step[2*WIDTH-1:WIDTH-1];
        w_ge  = (w_sum >= r_opnd);
        if (w_ge) begin
          w_sum = w_sum - r_opnd;
        end else begin
          w_sum = w_sum;
        end
        w_acc_step = {w_sum[WIDTH-1:0], w_acc_step[WIDTH-2:0], w_ge};
      end else begin
        // Add multiplicand on a set multiplier LSB, then shift right with carry.
        if (w_acc_step[0]) begin
          w_sum = {1'b0, w_acc_step[2*WIDTH-1:WIDTH]} + r_opnd;
        end else begin
          w_sum = {1'b0, w_acc_step[2*WIDTH-1:WIDTH]};
        end
        w_acc_step = {w_sum, w_acc_step[WIDTH-1:1]};
      end
    end
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_dbz || !r_op[0]) begin
      w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
      w_fix_lo = r_acc[WIDTH-1:0];
    end else if (!r_op[1]) begin
      if (r_sign_a ^ r_sign_b) begin
        w_fix_hi = w_neg_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = w_neg_acc[WIDTH-1:0];
      end else begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
      end
    end else begin
      // Quotient sign = sign_a ^ sign_b; remainder follows the dividend.
      if (r_sign_a ^ r_sign_b) begin
        w_fix_lo = -r_acc[WIDTH-1:0];
      end else begin
        w_fix_lo = r_acc[WIDTH-1:0];
      end
      if (r_sign_a) begin
        w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
      end else begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Datapath: operand latch, iteration and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op      <= 2'b00;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_dbz     <= 1'b0;
      r_cnt     <= {CW{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_opnd    <= {(WIDTH+1){1'b0}};
      r_out_hi  <= {WIDTH{1'b0}};
      r_out_lo  <= {WIDTH{1'b0}};
      r_out_dbz <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op;
      r_sign_a <= w_a_ext[WIDTH];
      r_sign_b <= w_b_ext[WIDTH];
      r_dbz    <= w_div0;
      r_cnt    <= CNT_N;
      if (w_div0) begin
        // Remainder = raw dividend, quotient = all ones.
        r_acc  <= {in_a, {WIDTH{1'b1}}};
        r_opnd <= w_b_mag;
      end else if (op[1]) begin
        r_acc  <= {{WIDTH{1'b0}}, w_a_mag[WIDTH-1:0]};
        r_opnd <= w_b_mag;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, w_b_mag[WIDTH-1:0]};
        r_opnd <= w_a_mag;
      end
    end else if (r_state == S_CALC && !annul) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt - CNT_ONE;
    end else if (r_state == S_FIX && !annul) begin
      r_out_hi  <= w_fix_hi;
      r_out_lo  <= w_fix_lo;
      r_out_dbz <= r_dbz;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign out_hi      = r_out_hi;
  assign out_lo      = r_out_lo;
  assign div_by_zero = r_out_dbz & out_valid;

endmodule
